// File: rtl/alu_control_seq.sv
// Registered ALU control decoder: 1-cycle decode latency, MUL/DIV hold ALUCtrl for N cycles.
// Backpressure: InReady drops while a multi-cycle op is busy; Flush aborts it, Reset wins over all.
module alu_control_seq #(
  parameter int OPC_W      = 4,
  parameter int FUNCT_W    = 2,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         ALUOp,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               InValid,
  input  logic               Flush,
  output logic               InReady,
  output logic [CTRL_W-1:0]  ALUCtrl,
  output logic               CtrlValid,
  output logic               MultiCycle,
  output logic               Busy,
  output logic               Done,
  output logic               Illegal
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CTRL_W-1:0]   alu_ctrl_q;
  logic                ctrl_valid_q;
  logic                multi_q;
  logic                busy_q;
  logic                done_q;
  logic                illegal_q;

  logic [CTRL_W-1:0]   ctrl_d;
  logic                illegal_d;
  logic                multi_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                accept;

  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b1;
    multi_d   = 1'b0;
    cnt_d     = '0;
    case (ALUOp)
      2'b00: begin ctrl_d = CTRL_W'(4'b0100); illegal_d = 1'b0; end
      2'b01: begin ctrl_d = CTRL_W'(4'b1100); illegal_d = 1'b0; end
      2'b10: begin
        case (Opcode)
          OPC_W'(0): begin
            if (Funct == FUNCT_W'(0))      begin ctrl_d = CTRL_W'(4'b0000); illegal_d = 1'b0; end
            else if (Funct == FUNCT_W'(1)) begin ctrl_d = CTRL_W'(4'b0010); illegal_d = 1'b0; end
            else if (Funct == FUNCT_W'(2)) begin ctrl_d = CTRL_W'(4'b0011); illegal_d = 1'b0; end
          end
          OPC_W'(1): begin
            if (Funct == FUNCT_W'(0))      begin ctrl_d = CTRL_W'(4'b0100); illegal_d = 1'b0; end
            else if (Funct == FUNCT_W'(1)) begin ctrl_d = CTRL_W'(4'b1100); illegal_d = 1'b0; end
          end
          OPC_W'(2): begin
            if (Funct == FUNCT_W'(0))      begin ctrl_d = CTRL_W'(4'b0110); illegal_d = 1'b0; end
            else if (Funct == FUNCT_W'(1)) begin ctrl_d = CTRL_W'(4'b0111); illegal_d = 1'b0; end
          end
          OPC_W'(3): begin
            // Counter is loaded with N-1 so Busy stays up for exactly N cycles.
            if (Funct == FUNCT_W'(0)) begin
              ctrl_d = CTRL_W'(4'b1000); illegal_d = 1'b0; multi_d = 1'b1;
              cnt_d  = CNT_W'(MUL_CYCLES - 1);
            end else if (Funct == FUNCT_W'(1)) begin
              ctrl_d = CTRL_W'(4'b1001); illegal_d = 1'b0; multi_d = 1'b1;
              cnt_d  = CNT_W'(DIV_CYCLES - 1);
            end
          end
          default: ;
        endcase
      end
      2'b11: begin
        case (Opcode)
          OPC_W'(9):  begin ctrl_d = CTRL_W'(4'b0100); illegal_d = 1'b0; end
          OPC_W'(10): begin ctrl_d = CTRL_W'(4'b1100); illegal_d = 1'b0; end
          OPC_W'(11): begin ctrl_d = CTRL_W'(4'b0001); illegal_d = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  assign accept = InValid && (state_q == IDLE) && !Flush;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_ctrl_q   <= '0;
      ctrl_valid_q <= 1'b0;
      multi_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_ctrl_q   <= ctrl_d;
            illegal_q    <= illegal_d;
            multi_q      <= multi_d;
            ctrl_valid_q <= 1'b1;
            if (multi_d) begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= cnt_d;
            end
          end
        end
        BUSY: begin
          if (Flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign InReady    = (state_q == IDLE);
  assign ALUCtrl    = alu_ctrl_q;
  assign CtrlValid  = ctrl_valid_q;
  assign MultiCycle = multi_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench: decode vector table, hand-written multi-cycle sequences, random run vs model.
module tb_alu_control_seq;
  localparam int MULN = 4;
  localparam int DIVN = 16;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] ALUOp;
  logic [3:0] Opcode;
  logic [1:0] Funct;
  logic       InValid, Flush;
  logic       InReady, CtrlValid, MultiCycle, Busy, Done, Illegal;
  logic [3:0] ALUCtrl;

  int tests = 0;
  int fails = 0;

  alu_control_seq #(
    .OPC_W(4), .FUNCT_W(2), .CTRL_W(4), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .Opcode(Opcode), .Funct(Funct),
    .InValid(InValid), .Flush(Flush), .InReady(InReady), .ALUCtrl(ALUCtrl),
    .CtrlValid(CtrlValid), .MultiCycle(MultiCycle), .Busy(Busy), .Done(Done),
    .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Reference model: remaining busy cycles plus the expected visible outputs.
  int         m_rem;
  logic [3:0] m_ctrl;
  logic       m_cv, m_mc, m_done, m_ill;

  // R-format table indexed [opcode][funct]; -1 marks an undefined slot.
  int rtab [4][3] = '{'{0, 2, 3}, '{4, 12, -1}, '{6, 7, -1}, '{8, 9, -1}};
  int itab [3]    = '{4, 12, 1};

  function automatic void ref_decode(input logic [1:0] a, input logic [3:0] o,
                                     input logic [1:0] f, output logic [3:0] c,
                                     output logic il, output int cyc);
    c = 4'd0; il = 1'b1; cyc = 0;
    if (a == 2'd0) begin c = 4'd4; il = 1'b0; end
    else if (a == 2'd1) begin c = 4'd12; il = 1'b0; end
    else if (a == 2'd2) begin
      if (o < 4 && f < 3 && rtab[o][f] >= 0) begin
        c = 4'(rtab[o][f]); il = 1'b0;
        if (o == 4'd3) cyc = (f == 2'd0) ? MULN : DIVN;
      end
    end else if (o >= 4'd9 && o <= 4'd11) begin
      c = 4'(itab[o - 4'd9]); il = 1'b0;
    end
  endfunction

  task automatic model_step(input logic [1:0] a, input logic [3:0] o, input logic [1:0] f,
                            input logic v, input logic fl, input logic r);
    logic [3:0] c;
    logic       il;
    int         cyc;
    if (r) begin
      m_rem = 0; m_ctrl = 4'd0; m_cv = 0; m_mc = 0; m_done = 0; m_ill = 0;
      return;
    end
    m_cv = 0; m_ill = 0; m_done = 0;
    if (m_rem > 0) begin
      if (fl) begin
        m_rem = 0; m_mc = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (v && !fl) begin
      ref_decode(a, o, f, c, il, cyc);
      m_ctrl = c; m_ill = il; m_cv = 1; m_mc = (cyc > 0); m_rem = cyc;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output at the falling edge.
  task automatic tick(input logic [1:0] a, input logic [3:0] o, input logic [1:0] f,
                      input logic v, input logic fl, input logic r);
    ALUOp = a; Opcode = o; Funct = f; InValid = v; Flush = fl; Reset = r;
    @(posedge Clock);
    model_step(a, o, f, v, fl, r);
    @(negedge Clock);
    chk("ALUCtrl", 32'(ALUCtrl), 32'(m_ctrl));
    chk("CtrlValid", 32'(CtrlValid), 32'(m_cv));
    chk("Illegal", 32'(Illegal), 32'(m_ill));
    chk("MultiCycle", 32'(MultiCycle), 32'(m_mc));
    chk("Busy", 32'(Busy), 32'(m_rem > 0));
    chk("Done", 32'(Done), 32'(m_done));
    chk("InReady", 32'(InReady), 32'(m_rem == 0));
  endtask

  task automatic idle();
    tick(2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [3:0] opc;
    logic [1:0] funct;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] a, input logic [3:0] o, input logic [1:0] f,
                              input logic [3:0] c, input logic il);
    vec_t v;
    v.aluop = a; v.opc = o; v.funct = f; v.ctrl = c; v.ill = il;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(2'b00, 4'd0, 2'd0, 4'b0100, 1'b0));
    vecs.push_back(mk(2'b00, 4'd5, 2'd3, 4'b0100, 1'b0));
    vecs.push_back(mk(2'b01, 4'd0, 2'd0, 4'b1100, 1'b0));
    vecs.push_back(mk(2'b10, 4'd0, 2'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(2'b10, 4'd0, 2'd1, 4'b0010, 1'b0));
    vecs.push_back(mk(2'b10, 4'd0, 2'd2, 4'b0011, 1'b0));
    vecs.push_back(mk(2'b10, 4'd1, 2'd0, 4'b0100, 1'b0));
    vecs.push_back(mk(2'b10, 4'd1, 2'd1, 4'b1100, 1'b0));
    vecs.push_back(mk(2'b10, 4'd2, 2'd0, 4'b0110, 1'b0));
    vecs.push_back(mk(2'b10, 4'd2, 2'd1, 4'b0111, 1'b0));
    vecs.push_back(mk(2'b11, 4'd9, 2'd0, 4'b0100, 1'b0));
    vecs.push_back(mk(2'b11, 4'd10, 2'd2, 4'b1100, 1'b0));
    vecs.push_back(mk(2'b11, 4'd11, 2'd1, 4'b0001, 1'b0));
    vecs.push_back(mk(2'b10, 4'd0, 2'd3, 4'b0000, 1'b1));
    vecs.push_back(mk(2'b11, 4'd7, 2'd0, 4'b0000, 1'b1));
    vecs.push_back(mk(2'b10, 4'd1, 2'd2, 4'b0000, 1'b1));
    vecs.push_back(mk(2'b10, 4'd3, 2'd2, 4'b0000, 1'b1));
    vecs.push_back(mk(2'b10, 4'd4, 2'd0, 4'b0000, 1'b1));

    m_rem = 0; m_ctrl = 4'd0; m_cv = 0; m_mc = 0; m_done = 0; m_ill = 0;

    // Reset state and first OR decode.
    tick(2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_ctrl", 32'(ALUCtrl), 32'h0);
    chk("rst_ready", 32'(InReady), 32'h1);
    tick(2'b10, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("or_ctrl", 32'(ALUCtrl), 32'b0010);
    chk("or_valid", 32'(CtrlValid), 32'h1);
    idle();
    chk("or_hold", 32'(ALUCtrl), 32'b0010);
    chk("or_valid_drop", 32'(CtrlValid), 32'h0);

    // Back-to-back decode sweep.
    foreach (vecs[i]) begin
      tick(vecs[i].aluop, vecs[i].opc, vecs[i].funct, 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_ctrl", i), 32'(ALUCtrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_ill", i), 32'(Illegal), 32'(vecs[i].ill));
      chk($sformatf("vec%0d_valid", i), 32'(CtrlValid), 32'h1);
      chk($sformatf("vec%0d_ready", i), 32'(InReady), 32'h1);
      chk($sformatf("vec%0d_busy", i), 32'(Busy), 32'h0);
    end

    // MUL: 4 busy cycles, ignored InValid, ADD issued in the Done cycle.
    tick(2'b10, 4'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mul_ctrl", 32'(ALUCtrl), 32'b1000);
    chk("mul_mc", 32'(MultiCycle), 32'h1);
    chk("mul_busy1", 32'(Busy), 32'h1);
    tick(2'b00, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mul_ignore", 32'(CtrlValid), 32'h0);
    chk("mul_busy2", 32'(Busy), 32'h1);
    idle();
    chk("mul_busy3", 32'(Busy), 32'h1);
    idle();
    chk("mul_busy4", 32'(Busy), 32'h1);
    chk("mul_notready4", 32'(InReady), 32'h0);
    idle();
    chk("mul_done", 32'(Done), 32'h1);
    chk("mul_ready", 32'(InReady), 32'h1);
    tick(2'b00, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mul_b2b_ctrl", 32'(ALUCtrl), 32'b0100);
    chk("mul_b2b_valid", 32'(CtrlValid), 32'h1);
    chk("mul_b2b_done", 32'(Done), 32'h0);

    // DIV flushed in its 5th busy cycle.
    tick(2'b10, 4'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle();
    chk("div_busy5", 32'(Busy), 32'h1);
    tick(2'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("div_flush_busy", 32'(Busy), 32'h0);
    chk("div_flush_ready", 32'(InReady), 32'h1);
    chk("div_flush_ctrl", 32'(ALUCtrl), 32'b1001);
    for (int k = 0; k < 14; k++) idle();

    // Flush in IDLE suppresses the accept.
    tick(2'b01, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("idle_flush_valid", 32'(CtrlValid), 32'h0);

    // Reset in MUL's 2nd busy cycle, then SUB.
    tick(2'b10, 4'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    idle();
    tick(2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("mrst_ctrl", 32'(ALUCtrl), 32'h0);
    chk("mrst_busy", 32'(Busy), 32'h0);
    chk("mrst_ready", 32'(InReady), 32'h1);
    for (int k = 0; k < 4; k++) idle();
    tick(2'b01, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mrst_sub", 32'(ALUCtrl), 32'b1100);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] o;
      o = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      tick(2'($urandom_range(0, 3)), o, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
